// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states and
// the alignment rule used to reject badly aligned requests.
package lsu_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        WRITE = 2'b01,
        RESP  = 2'b10
    } lsu_state_e;

    // True when the low address bits do not suit the access size.
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = lo[0];
            SZ_WORD: bad = (lo != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Little-endian lane handling: extracts/extends load data from a memory word
// and merges sub-word store data into an old word.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  lo_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] ld_data_o,
    output logic [31:0] st_word_o
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Select the addressed byte and halfword lanes.
    always_comb begin
        byte_s = 8'h00;
        case (lo_i)
            2'd0:    byte_s = word_i[7:0];
            2'd1:    byte_s = word_i[15:8];
            2'd2:    byte_s = word_i[23:16];
            2'd3:    byte_s = word_i[31:24];
            default: byte_s = 8'h00;
        endcase
        if (lo_i[1]) begin
            half_s = word_i[31:16];
        end else begin
            half_s = word_i[15:0];
        end
    end

    // Zero- or sign-extend the selected lane.
    always_comb begin
        ld_data_o = 32'h0000_0000;
        case (size_i)
            SZ_BYTE: ld_data_o = unsigned_i ? {24'h00_0000, byte_s} : {{24{byte_s[7]}}, byte_s};
            SZ_HALF: ld_data_o = unsigned_i ? {16'h0000, half_s}    : {{16{half_s[15]}}, half_s};
            SZ_WORD: ld_data_o = word_i;
            default: ld_data_o = 32'h0000_0000;
        endcase
    end

    // Replace the addressed lane(s) of the old word with store data.
    always_comb begin
        st_word_o = word_i;
        case (size_i)
            SZ_BYTE: begin
                case (lo_i)
                    2'd0:    st_word_o[7:0]   = wdata_i[7:0];
                    2'd1:    st_word_o[15:8]  = wdata_i[7:0];
                    2'd2:    st_word_o[23:16] = wdata_i[7:0];
                    2'd3:    st_word_o[31:24] = wdata_i[7:0];
                    default: st_word_o        = word_i;
                endcase
            end
            SZ_HALF: begin
                if (lo_i[1]) begin
                    st_word_o[31:16] = wdata_i[15:0];
                end else begin
                    st_word_o[15:0] = wdata_i[15:0];
                end
            end
            SZ_WORD: st_word_o = wdata_i;
            default: st_word_o = word_i;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: turns byte/half/word CPU requests into word accesses on a
// combinational-read, synchronous-write data memory, with request checking.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int DEPTH_WORDS = 64
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        unsigned_ld,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        done,
    output logic        err,
    output logic        busy,
    output logic        mem_we,
    output logic [31:0] mem_a,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_rd
);

    localparam logic [31:0] ADDR_LIMIT = 32'(4 * DEPTH_WORDS);

    lsu_state_e  state_q, state_d;
    logic        err_q, err_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] addr_q, addr_d;
    logic [1:0]  lo_q, lo_d;
    logic [1:0]  size_q, size_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] old_q, old_d;

    logic        reject_s;
    logic [31:0] al_word_s, al_wdata_s, ld_data_s, st_word_s;
    logic [1:0]  al_lo_s, al_size_s;
    logic        mem_we_s;
    logic [31:0] mem_a_s, mem_wd_s;

    assign reject_s = (size == SZ_RSVD) || misaligned(size, addr[1:0]) || (addr >= ADDR_LIMIT);

    // In WRITE the aligner merges the captured request; otherwise it sees the live one.
    always_comb begin
        if (state_q == WRITE) begin
            al_word_s  = old_q;
            al_lo_s    = lo_q;
            al_size_s  = size_q;
            al_wdata_s = wdata_q;
        end else begin
            al_word_s  = mem_rd;
            al_lo_s    = addr[1:0];
            al_size_s  = size;
            al_wdata_s = wdata;
        end
    end

    lsu_lane_align u_align (
        .word_i     (al_word_s),
        .lo_i       (al_lo_s),
        .size_i     (al_size_s),
        .unsigned_i (unsigned_ld),
        .wdata_i    (al_wdata_s),
        .ld_data_o  (ld_data_s),
        .st_word_o  (st_word_s)
    );

    // Next-state and memory-port decode.
    always_comb begin
        state_d  = state_q;
        err_d    = err_q;
        rdata_d  = rdata_q;
        addr_d   = addr_q;
        lo_d     = lo_q;
        size_d   = size_q;
        wdata_d  = wdata_q;
        old_d    = old_q;
        mem_we_s = 1'b0;
        mem_a_s  = 32'h0000_0000;
        mem_wd_s = 32'h0000_0000;
        case (state_q)
            IDLE: begin
                mem_a_s = {addr[31:2], 2'b00};
                if (req) begin
                    if (reject_s) begin
                        err_d   = 1'b1;
                        rdata_d = 32'h0000_0000;
                        state_d = RESP;
                    end else if (!we) begin
                        err_d   = 1'b0;
                        rdata_d = ld_data_s;
                        state_d = RESP;
                    end else if (size == SZ_WORD) begin
                        mem_we_s = 1'b1;
                        mem_wd_s = wdata;
                        err_d    = 1'b0;
                        rdata_d  = 32'h0000_0000;
                        state_d  = RESP;
                    end else begin
                        addr_d  = {addr[31:2], 2'b00};
                        lo_d    = addr[1:0];
                        size_d  = size;
                        wdata_d = wdata;
                        old_d   = mem_rd;
                        err_d   = 1'b0;
                        rdata_d = 32'h0000_0000;
                        state_d = WRITE;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            WRITE: begin
                mem_a_s  = addr_q;
                mem_wd_s = st_word_s;
                mem_we_s = 1'b1;
                state_d  = RESP;
            end
            RESP: begin
                err_d   = 1'b0;
                rdata_d = 32'h0000_0000;
                state_d = IDLE;
            end
            default: begin
                err_d   = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State and capture registers, cleared immediately by reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            err_q   <= 1'b0;
            rdata_q <= 32'h0000_0000;
            addr_q  <= 32'h0000_0000;
            lo_q    <= 2'b00;
            size_q  <= SZ_BYTE;
            wdata_q <= 32'h0000_0000;
            old_q   <= 32'h0000_0000;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            addr_q  <= addr_d;
            lo_q    <= lo_d;
            size_q  <= size_d;
            wdata_q <= wdata_d;
            old_q   <= old_d;
        end
    end

    // The memory port is gated by reset so an aborted write never lands.
    assign mem_we = reset_n & mem_we_s;
    assign mem_a  = reset_n ? mem_a_s  : 32'h0000_0000;
    assign mem_wd = reset_n ? mem_wd_s : 32'h0000_0000;
    assign done   = (state_q == RESP);
    assign err    = done & err_q;
    assign rdata  = done ? rdata_q : 32'h0000_0000;
    assign busy   = (state_q != IDLE);

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a behavioural 64-word data memory.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset_n, req, we, unsigned_ld;
    logic [1:0]  size;
    logic [31:0] addr, wdata, rdata, mem_a, mem_wd, mem_rd;
    logic        done, err, busy, mem_we;
    logic        mem_init;
    logic [31:0] mem [64];
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    load_store_unit #(.DEPTH_WORDS(64)) dut (
        .clk(clk), .reset_n(reset_n), .req(req), .we(we), .size(size),
        .unsigned_ld(unsigned_ld), .addr(addr), .wdata(wdata), .rdata(rdata),
        .done(done), .err(err), .busy(busy), .mem_we(mem_we), .mem_a(mem_a),
        .mem_wd(mem_wd), .mem_rd(mem_rd)
    );

    assign mem_rd = mem[mem_a[7:2]];

    // Memory model: preload while mem_init is high, otherwise synchronous write.
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'h0000_0000;
            mem[0] <= 32'hFACE_FACE;
            mem[1] <= 32'h0000_0002;
            mem[2] <= 32'h1122_3344;
        end else if (mem_we) begin
            mem[mem_a[7:2]] <= mem_wd;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present a request just after a rising edge, then move to the sampling point.
    task automatic drive(input logic w, input logic [1:0] sz, input logic u,
                         input logic [31:0] a, input logic [31:0] d);
        @(posedge clk);
        #1;
        req = 1'b1; we = w; size = sz; unsigned_ld = u; addr = a; wdata = d;
        @(negedge clk);
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
        req = 1'b0;
        @(negedge clk);
    endtask

    logic        e_we [4]   = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [1:0]  e_sz [4]   = '{2'b10, 2'b01, 2'b10, 2'b11};
    logic [31:0] e_ad [4]   = '{32'h2, 32'h5, 32'h100, 32'h8};

    initial begin
        mem_init = 1'b1;
        reset_n = 1'b0;
        req = 1'b1; we = 1'b1; size = 2'b10; unsigned_ld = 1'b0;
        addr = 32'h1234_5678; wdata = 32'hFFFF_FFFF;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_rdata", rdata, 32'h0);
        check("rst_done", {31'h0, done}, 32'h0);
        check("rst_err", {31'h0, err}, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_mem_we", {31'h0, mem_we}, 32'h0);
        check("rst_mem_wd", mem_wd, 32'h0);
        check("rst_mem_a", mem_a, 32'h0);
        req = 1'b0; mem_init = 1'b0; reset_n = 1'b1;

        drive(1'b0, 2'b00, 1'b0, 32'h1, 32'h0);
        check("lb1_n_done", {31'h0, done}, 32'h0);
        check("lb1_n_we", {31'h0, mem_we}, 32'h0);
        nxt();
        check("lb1_rdata", rdata, 32'hFFFF_FFFA);
        check("lb1_done", {31'h0, done}, 32'h1);
        check("lb1_err", {31'h0, err}, 32'h0);
        check("lb1_we", {31'h0, mem_we}, 32'h0);
        nxt();
        check("lb1_done_low", {31'h0, done}, 32'h0);

        drive(1'b0, 2'b00, 1'b1, 32'h0, 32'h0);
        nxt();
        check("lbu0_rdata", rdata, 32'h0000_00CE);
        drive(1'b0, 2'b01, 1'b0, 32'h2, 32'h0);
        nxt();
        check("lh2_rdata", rdata, 32'hFFFF_FACE);
        check("lh2_done", {31'h0, done}, 32'h1);

        drive(1'b1, 2'b01, 1'b0, 32'h6, 32'h0000_1234);
        check("sh_n_we", {31'h0, mem_we}, 32'h0);
        nxt();
        check("sh_n1_we", {31'h0, mem_we}, 32'h1);
        check("sh_n1_a", mem_a, 32'h4);
        check("sh_n1_wd", mem_wd, 32'h1234_0002);
        check("sh_n1_done", {31'h0, done}, 32'h0);
        check("sh_n1_busy", {31'h0, busy}, 32'h1);
        nxt();
        check("sh_n2_done", {31'h0, done}, 32'h1);
        check("sh_n2_we", {31'h0, mem_we}, 32'h0);
        check("sh_n2_err", {31'h0, err}, 32'h0);
        drive(1'b0, 2'b10, 1'b0, 32'h4, 32'h0);
        nxt();
        check("lw4_rdata", rdata, 32'h1234_0002);

        drive(1'b1, 2'b10, 1'b0, 32'hFC, 32'hDEAD_BEEF);
        check("sw_n_we", {31'h0, mem_we}, 32'h1);
        check("sw_n_a", mem_a, 32'hFC);
        check("sw_n_wd", mem_wd, 32'hDEAD_BEEF);
        nxt();
        check("sw_done", {31'h0, done}, 32'h1);
        check("sw_mem63", mem[63], 32'hDEAD_BEEF);

        for (int i = 0; i < 4; i++) begin
            drive(e_we[i], e_sz[i], 1'b0, e_ad[i], 32'hBAD0_BAD0);
            check($sformatf("err%0d_n_we", i), {31'h0, mem_we}, 32'h0);
            nxt();
            check($sformatf("err%0d_done", i), {31'h0, done}, 32'h1);
            check($sformatf("err%0d_err", i), {31'h0, err}, 32'h1);
            check($sformatf("err%0d_we", i), {31'h0, mem_we}, 32'h0);
            check($sformatf("err%0d_mem1", i), mem[1], 32'h1234_0002);
            check($sformatf("err%0d_mem2", i), mem[2], 32'h1122_3344);
        end
        check("mem0_intact", mem[0], 32'hFACE_FACE);

        drive(1'b1, 2'b00, 1'b0, 32'h8, 32'h0000_00AA);
        check("rw_n_busy", {31'h0, busy}, 32'h0);
        @(posedge clk);
        #1;
        req = 1'b0;
        check("rw_write_we", {31'h0, mem_we}, 32'h1);
        #2;
        reset_n = 1'b0;
        #1;
        check("rw_rst_we", {31'h0, mem_we}, 32'h0);
        check("rw_rst_busy", {31'h0, busy}, 32'h0);
        check("rw_rst_done", {31'h0, done}, 32'h0);
        @(posedge clk);
        #1;
        check("rw_mem2", mem[2], 32'h1122_3344);
        @(negedge clk);
        reset_n = 1'b1;

        drive(1'b1, 2'b00, 1'b0, 32'h9, 32'h0000_0055);
        nxt();
        check("sb9_wd", mem_wd, 32'h1122_5544);
        check("sb9_a", mem_a, 32'h8);
        nxt();
        check("sb9_done", {31'h0, done}, 32'h1);
        drive(1'b0, 2'b00, 1'b1, 32'h9, 32'h0);
        nxt();
        check("lbu9_rdata", rdata, 32'h0000_0055);
        check("sb9_mem2", mem[2], 32'h1122_5544);
        nxt();
        check("end_done", {31'h0, done}, 32'h0);
        check("end_busy", {31'h0, busy}, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits between the CPU datapath and the 64-word data memory (combinational read, synchronous write, word-aligned, 32-bit).
- Converts CPU load/store requests of byte, halfword or word size into word accesses on the memory port.
- Sub-word stores are done by read-modify-write; loads are returned sign- or zero-extended.
- Detects misaligned, out-of-range and reserved-size requests and flags them instead of touching memory.

Parameters:
- DEPTH_WORDS, 64, number of 32-bit words in the attached data memory; byte addresses at or above 4*DEPTH_WORDS are out of range.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req  in  1  request valid; held by the CPU until done.
- we  in  1  1 = store, 0 = load.
- size  in  2  access size: 00 byte, 01 half, 10 word, 11 reserved.
- unsigned_ld  in  1  1 = zero-extend loads, 0 = sign-extend.
- addr  in  32  byte address.
- wdata  in  32  store data, right-justified.
- rdata  out  32  load result, valid while done=1.
- done  out  1  one-cycle completion pulse.
- err  out  1  valid with done; the request was rejected.
- busy  out  1  high whenever state != IDLE.
- mem_we  out  1  write enable to data memory.
- mem_a  out  32  word-aligned byte address to data memory (bits [1:0] = 0).
- mem_wd  out  32  write data to data memory.
- mem_rd  in  32  combinational read data from data memory.

Behaviour:
- Byte lanes are little-endian: byte n occupies bits [8n+7:8n]. A halfword at addr[1]=h occupies bits [16h+15:16h].
- Error check happens in IDLE when req=1. A request is rejected if any of these holds:
  - size = 11;
  - half with addr[0] = 1;
  - word with addr[1:0] != 0;
  - addr >= 4*DEPTH_WORDS.
- FSM states: IDLE, WRITE, RESP. All state and output registers are cleared immediately on reset_n low.
- IDLE:
  - mem_a = {addr[31:2], 2'b00} combinationally.
  - req and rejected: set err_q=1, go to RESP. No memory write.
  - req, load: capture the extracted and extended mem_rd into rdata_q, go to RESP.
  - req, word store: mem_we=1 combinationally in this same cycle, mem_wd=wdata, go to RESP.
  - req, byte/half store: capture addr, wdata, size and the old word mem_rd, go to WRITE. mem_we=0.
  - No req: stay in IDLE.
- WRITE:
  - mem_a = captured aligned address.
  - mem_wd = old word with the addressed lane(s) replaced by wdata[7:0] or wdata[15:0].
  - mem_we=1 for exactly this cycle, then go to RESP.
- RESP: done=1, rdata=rdata_q (zero for stores), err=err_q. Clear err_q and go to IDLE.
- Latency, counted from the acceptance edge N:
  - load, word store and error: done in cycle N+1;
  - sub-word store: done in cycle N+2.
- The CPU must deassert req or present a new request on the cycle after done. req while busy=1 is ignored.
- mem_we is decoded combinationally from state and inputs. An asynchronous reset during WRITE drops mem_we immediately, so memory is unchanged.
- Reset values: rdata=0, done=0, err=0, busy=0, mem_we=0, mem_wd=0, mem_a=0 (while reset_n=0).

Decomposition:
- Shared package lsu_pkg holds:
  - size encodings SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10;
  - FSM state encodings IDLE, WRITE, RESP.
- One combinational sub-module, lsu_lane_align, does two jobs:
  - extract and extend the load value from a 32-bit word, addr[1:0], size and unsigned_ld;
  - merge store data into an old word.
- The FSM, error checks and registers stay in load_store_unit.

Test Plan:
- Memory word0 = 0xFACEFACE; load byte, signed, addr 0x1 -> rdata 0xFFFFFFFA, done at N+1, err=0, mem_we never high.
- Load byte, unsigned, addr 0x0 -> rdata 0x000000CE. Load half, signed, addr 0x2 -> rdata 0xFFFFFACE.
- Word1 = 0x00000002; store half wdata 0x00001234 at addr 0x6:
  - mem_we high exactly one cycle (N+1) with mem_a 0x4 and mem_wd 0x12340002;
  - done at N+2;
  - a subsequent word load of 0x4 returns 0x12340002.
- Store word 0xDEADBEEF at addr 0xFC -> mem_we in cycle N, word63 = 0xDEADBEEF, done at N+1.
- Each of these -> done with err=1 at N+1, no mem_we, memory unchanged:
  - word load at addr 0x2;
  - half store at addr 0x5;
  - load at addr 0x100;
  - size 11.
- Start a byte store at addr 0x8. While in WRITE, pull reset_n low mid-cycle -> mem_we drops immediately, word2 unchanged, busy=0, done=0. Back-to-back requests after release complete normally.
